// File: rtl/fs_pkg.sv
// Shared definitions for the fetch sequencer: state encoding and default widths.
package fs_pkg;

    localparam int FS_AW_DEF     = 16;
    localparam int FS_IW_DEF     = 16;
    localparam int FS_PERF_W_DEF = 16;

    typedef enum logic [2:0] {
        REDIR = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        HOLD  = 3'd3,
        DRAIN = 3'd4
    } fs_state_e;

endpackage

// File: rtl/fs_perf_cnt.sv
// Saturating up-counter with enable, used for the optional fetch performance counters.
module fs_perf_cnt
    import fs_pkg::*;
#(
    parameter int W = FS_PERF_W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (en && (cnt != {W{1'b1}})) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/fetch_seq.sv
// Fetch sequencer: PC inc/jump control, single-outstanding memory fetch, instruction register.
// Optional performance counters are enabled by defining FS_PERF_CNT_EN.
module fetch_seq
    import fs_pkg::*;
#(
    parameter int AW     = FS_AW_DEF,
    parameter int IW     = FS_IW_DEF,
    parameter int PERF_W = FS_PERF_W_DEF
) (
    input  logic              FS_clk,
    input  logic              FS_rst,
    input  logic [AW-1:0]     FS_pc_addr,
    output logic              FS_pc_inc,
    output logic              FS_pc_jump,
    output logic [AW-1:0]     FS_pc_target,
    output logic              FS_mem_req,
    output logic [AW-1:0]     FS_mem_addr,
    input  logic              FS_mem_gnt,
    input  logic              FS_mem_rvalid,
    input  logic [IW-1:0]     FS_mem_rdata,
    output logic [IW-1:0]     FS_ir,
    output logic              FS_ir_valid,
    input  logic              FS_ir_ready,
    input  logic              FS_redirect,
    input  logic [AW-1:0]     FS_redirect_tgt
`ifdef FS_PERF_CNT_EN
    ,
    output logic [PERF_W-1:0] FS_perf_fetched,
    output logic [PERF_W-1:0] FS_perf_stall
`endif
);

    fs_state_e state_q, state_d;
    logic      first_hold_q;
    logic      ir_load;
    logic      ir_take;
    logic      inc_d;

    assign FS_mem_req  = (state_q == REQ);
    assign FS_mem_addr = FS_pc_addr;

    // Next-state and handshake decode; a redirect overrides every other event.
    always_comb begin
        state_d = state_q;
        ir_load = 1'b0;
        ir_take = 1'b0;
        inc_d   = 1'b0;
        unique case (state_q)
            REDIR: state_d = FS_redirect ? REDIR : REQ;
            REQ: begin
                if (FS_redirect)     state_d = FS_mem_gnt ? DRAIN : REDIR;
                else if (FS_mem_gnt) state_d = WAIT;
            end
            WAIT: begin
                if (FS_redirect) begin
                    state_d = FS_mem_rvalid ? REDIR : DRAIN;
                end else if (FS_mem_rvalid) begin
                    state_d = HOLD;
                    ir_load = 1'b1;
                end
            end
            HOLD: begin
                // The inc decided in the first HOLD cycle is visible one cycle later,
                // so HOLD is left only once that pulse has reached the PC.
                inc_d   = first_hold_q && !FS_redirect;
                ir_take = FS_ir_valid && FS_ir_ready && !FS_redirect;
                if (FS_redirect) begin
                    state_d = REDIR;
                end else if (!first_hold_q && (!FS_ir_valid || FS_ir_ready)) begin
                    state_d = REQ;
                end
            end
            DRAIN: begin
                // A redirect coinciding with the drained response still needs one settle cycle.
                if (FS_redirect)        state_d = FS_mem_rvalid ? REDIR : DRAIN;
                else if (FS_mem_rvalid) state_d = REQ;
            end
            default: state_d = REDIR;
        endcase
    end

    always_ff @(posedge FS_clk) begin
        if (FS_rst) begin
            state_q      <= REDIR;
            first_hold_q <= 1'b0;
            FS_pc_inc    <= 1'b0;
            FS_pc_jump   <= 1'b0;
            FS_pc_target <= '0;
            FS_ir        <= '0;
            FS_ir_valid  <= 1'b0;
        end else begin
            state_q      <= state_d;
            first_hold_q <= ir_load;
            FS_pc_inc    <= inc_d;
            FS_pc_jump   <= FS_redirect;
            if (FS_redirect) FS_pc_target <= FS_redirect_tgt;
            if (ir_load)     FS_ir        <= FS_mem_rdata;
            if (FS_redirect)  FS_ir_valid <= 1'b0;
            else if (ir_load) FS_ir_valid <= 1'b1;
            else if (ir_take) FS_ir_valid <= 1'b0;
        end
    end

`ifdef FS_PERF_CNT_EN
    fs_perf_cnt #(.W(PERF_W)) u_cnt_fetched (
        .clk (FS_clk),
        .rst (FS_rst),
        .en  (ir_take),
        .cnt (FS_perf_fetched)
    );

    fs_perf_cnt #(.W(PERF_W)) u_cnt_stall (
        .clk (FS_clk),
        .rst (FS_rst),
        .en  ((state_q == REQ) || (state_q == WAIT)),
        .cnt (FS_perf_stall)
    );
`endif

endmodule

// File: tb/tb_fetch_seq.sv
// Directed bench for fetch_seq with a behavioural PC and hand-driven memory responses.
module tb_fetch_seq;

    localparam int AW = 16;
    localparam int IW = 16;
    localparam int PW = 4;

    logic          FS_clk = 1'b0;
    logic          FS_rst = 1'b1;
    logic [AW-1:0] FS_pc_addr;
    logic          FS_pc_inc, FS_pc_jump, FS_mem_req;
    logic [AW-1:0] FS_pc_target, FS_mem_addr;
    logic          FS_mem_gnt = 1'b0, FS_mem_rvalid = 1'b0;
    logic [IW-1:0] FS_mem_rdata = '0;
    logic [IW-1:0] FS_ir;
    logic          FS_ir_valid;
    logic          FS_ir_ready = 1'b0;
    logic          FS_redirect = 1'b0;
    logic [AW-1:0] FS_redirect_tgt = '0;
`ifdef FS_PERF_CNT_EN
    logic [PW-1:0] FS_perf_fetched, FS_perf_stall;
`endif

    int n_vec = 0;
    int n_err = 0;
    int inc_cnt;
    int bad;

    fetch_seq #(.AW(AW), .IW(IW), .PERF_W(PW)) dut (
        .FS_clk          (FS_clk),
        .FS_rst          (FS_rst),
        .FS_pc_addr      (FS_pc_addr),
        .FS_pc_inc       (FS_pc_inc),
        .FS_pc_jump      (FS_pc_jump),
        .FS_pc_target    (FS_pc_target),
        .FS_mem_req      (FS_mem_req),
        .FS_mem_addr     (FS_mem_addr),
        .FS_mem_gnt      (FS_mem_gnt),
        .FS_mem_rvalid   (FS_mem_rvalid),
        .FS_mem_rdata    (FS_mem_rdata),
        .FS_ir           (FS_ir),
        .FS_ir_valid     (FS_ir_valid),
        .FS_ir_ready     (FS_ir_ready),
        .FS_redirect     (FS_redirect),
        .FS_redirect_tgt (FS_redirect_tgt)
`ifdef FS_PERF_CNT_EN
        ,
        .FS_perf_fetched (FS_perf_fetched),
        .FS_perf_stall   (FS_perf_stall)
`endif
    );

    always #5 FS_clk = ~FS_clk;

    // Program counter: jump has priority over inc, resets to 0x0010.
    always @(posedge FS_clk) begin
        if (FS_rst)          FS_pc_addr <= 16'h0010;
        else if (FS_pc_jump) FS_pc_addr <= FS_pc_target;
        else if (FS_pc_inc)  FS_pc_addr <= FS_pc_addr + 16'd1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge FS_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One plain fetch with gnt on req, rvalid next cycle and decode ready; ends back in REQ.
    task automatic fetch(input logic [IW-1:0] data);
        FS_mem_gnt = 1'b1;
        tick();
        FS_mem_gnt = 1'b0; FS_mem_rvalid = 1'b1; FS_mem_rdata = data;
        tick();
        FS_mem_rvalid = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        // Reset values
        FS_rst = 1'b1;
        tick(); tick();
        #1;
        chk("rst_pc_inc", FS_pc_inc, 0);
        chk("rst_pc_jump", FS_pc_jump, 0);
        chk("rst_pc_target", FS_pc_target, 0);
        chk("rst_ir", FS_ir, 0);
        chk("rst_ir_valid", FS_ir_valid, 0);
        chk("rst_mem_req", FS_mem_req, 0);
        FS_rst = 1'b0;

        // Basic fetch, 4-cycle period
        tick();
        chk("f1_req", FS_mem_req, 1);
        chk("f1_addr", FS_mem_addr, 16'h0010);
        FS_mem_gnt = 1'b1;
        tick();
        FS_mem_gnt = 1'b0; FS_mem_rvalid = 1'b1; FS_mem_rdata = 16'hA001;
        #1;
        chk("f1_wait_noreq", FS_mem_req, 0);
        tick();
        FS_mem_rvalid = 1'b0; FS_ir_ready = 1'b1;
        #1;
        chk("f1_ir", FS_ir, 16'hA001);
        chk("f1_ir_valid", FS_ir_valid, 1);
        chk("f1_inc_early", FS_pc_inc, 0);
        tick();
        chk("f1_valid_drop", FS_ir_valid, 0);
        chk("f1_inc", FS_pc_inc, 1);
        chk("f1_hold_noreq", FS_mem_req, 0);
        tick();
        chk("f2_req", FS_mem_req, 1);
        chk("f2_addr", FS_mem_addr, 16'h0011);
        chk("f2_inc_off", FS_pc_inc, 0);

        // Decode stalls in HOLD
        FS_mem_gnt = 1'b1; FS_ir_ready = 1'b0;
        tick();
        FS_mem_gnt = 1'b0; FS_mem_rvalid = 1'b1; FS_mem_rdata = 16'hB002;
        tick();
        FS_mem_rvalid = 1'b0;
        inc_cnt = 0; bad = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            inc_cnt += int'(FS_pc_inc);
            if (FS_ir !== 16'hB002 || FS_ir_valid !== 1'b1 || FS_mem_req !== 1'b0) bad++;
            tick();
        end
        chk("st_hold_stable", bad, 0);
        FS_ir_ready = 1'b1;
        tick();
        chk("st_inc_once", inc_cnt, 1);
        chk("st_req", FS_mem_req, 1);
        chk("st_valid_drop", FS_ir_valid, 0);
        chk("st_addr", FS_mem_addr, 16'h0012);

        // Redirect while waiting; late response is drained
        FS_mem_gnt = 1'b1;
        tick();
        FS_mem_gnt = 1'b0; FS_redirect = 1'b1; FS_redirect_tgt = 16'h0040;
        tick();
        FS_redirect = 1'b0;
        #1;
        chk("rw_jump", FS_pc_jump, 1);
        chk("rw_target", FS_pc_target, 16'h0040);
        bad = 0;
        tick();
        bad += int'(FS_ir_valid) + int'(FS_mem_req);
        tick();
        bad += int'(FS_ir_valid) + int'(FS_mem_req);
        FS_mem_rvalid = 1'b1; FS_mem_rdata = 16'hDEAD;
        tick();
        FS_mem_rvalid = 1'b0;
        #1;
        chk("rw_drain_quiet", bad, 0);
        chk("rw_no_dead", FS_ir_valid, 0);
        chk("rw_req", FS_mem_req, 1);
        chk("rw_addr", FS_mem_addr, 16'h0040);

        // Redirect coinciding with rvalid
        FS_mem_gnt = 1'b1;
        tick();
        FS_mem_gnt = 1'b0; FS_mem_rvalid = 1'b1; FS_mem_rdata = 16'h1234;
        FS_redirect = 1'b1; FS_redirect_tgt = 16'h0080;
        tick();
        FS_mem_rvalid = 1'b0; FS_redirect = 1'b0;
        #1;
        chk("rv_jump", FS_pc_jump, 1);
        chk("rv_target", FS_pc_target, 16'h0080);
        chk("rv_no_valid", FS_ir_valid, 0);
        chk("rv_no_inc", FS_pc_inc, 0);
        tick();
        chk("rv_no_inc2", FS_pc_inc, 0);
        chk("rv_req", FS_mem_req, 1);
        chk("rv_addr", FS_mem_addr, 16'h0080);

        // Grant withheld, then redirect withdraws the request
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (FS_mem_req !== 1'b1 || FS_mem_addr !== 16'h0080) bad++;
        end
        chk("ng_req_held", bad, 0);
        FS_redirect = 1'b1; FS_redirect_tgt = 16'h00C0;
        tick();
        FS_redirect = 1'b0;
        #1;
        chk("ng_withdrawn", FS_mem_req, 0);
        chk("ng_target", FS_pc_target, 16'h00C0);
        tick();
        chk("ng_req_tgt", FS_mem_req, 1);
        chk("ng_addr_tgt", FS_mem_addr, 16'h00C0);
        FS_mem_gnt = 1'b1;
        tick();
        FS_mem_gnt = 1'b0; FS_mem_rvalid = 1'b1; FS_mem_rdata = 16'hC0DE;
        tick();
        FS_mem_rvalid = 1'b0;
        #1;
        chk("ng_ir", FS_ir, 16'hC0DE);
        tick(); tick();
        chk("ng_next_addr", FS_mem_addr, 16'h00C1);

        // Reset while waiting; late rvalid is ignored
        FS_mem_gnt = 1'b1;
        tick();
        FS_mem_gnt = 1'b0; FS_rst = 1'b1;
        tick();
        FS_rst = 1'b0; FS_mem_rvalid = 1'b1; FS_mem_rdata = 16'hBAD1;
        #1;
        chk("mr_no_req", FS_mem_req, 0);
        tick();
        FS_mem_rvalid = 1'b0;
        #1;
        chk("mr_req", FS_mem_req, 1);
        chk("mr_addr", FS_mem_addr, 16'h0010);
        tick();
        chk("mr_no_valid", FS_ir_valid, 0);
        chk("mr_still_req", FS_mem_req, 1);

`ifdef FS_PERF_CNT_EN
        for (int i = 0; i < 20; i++) fetch(16'h5000 + 16'(i));
        chk("pf_fetched_sat", FS_perf_fetched, 4'hF);
        chk("pf_stall_sat", FS_perf_stall, 4'hF);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
